// File: rtl/vmem_pkg.sv
// vmem_pkg: shared constants, FSM state encoding and queue entry layout for the VGA text-memory write queue.
package vmem_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int VMEM_CHARS = 10240;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_WRITE    = 2'd2,
        ST_CLR_WAIT = 2'd3
    } vmq_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [7:0]            chr;
    } vmq_entry_t;

endpackage

// File: rtl/vmemq_fifo.sv
// vmemq_fifo: synchronous FIFO with wrap-around pointers (extra MSB distinguishes full from empty).
// Exposes the head and the entry behind it so the scheduler can chain writes without a bubble.
module vmemq_fifo #(
    parameter int DATA_W = 23,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] head_o,
    output logic [DATA_W-1:0] head_next_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTR_W:0]    level_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    wr_ptr_q;
    logic [PTR_W:0]    rd_ptr_q;
    logic [PTR_W:0]    rd_next_s;

    assign rd_next_s   = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    assign level_o     = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head_o      = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_next_o = mem_q[rd_next_s[PTR_W-1:0]];

    // Pointer update; pop is ignored on an empty queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_next_s;
            end
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/vmem_write_queue.sv
// vmem_write_queue: posted-write scheduler feeding VGA text RAM with a SETUP / WRITE(hold) wen sequence.
// Define VMEM_CLEAR_EN to add the hardware clear-screen sweep (clear_req / clear_char / clear_busy).
module vmem_write_queue
    import vmem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int FIFO_DEPTH  = 8,
    parameter int PTR_W       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_char,
    output logic              wr_ready,
    output logic              stall,
    output logic              busy,
    output logic [PTR_W:0]    level,
    output logic [ADDR_W-1:0] vga_addr,
    output logic [7:0]        vga_char,
    output logic              vga_wen
`ifdef VMEM_CLEAR_EN
    ,
    input  logic              clear_req,
    input  logic [7:0]        clear_char,
    output logic              clear_busy
`endif
);

    localparam int ENT_W  = ADDR_W + 8;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    vmq_state_e        state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              full_s;
    logic              empty_s;
    logic              accept_s;
    logic              last_write_s;
    logic              pop_s;
    logic              more_s;
    logic [ENT_W-1:0]  head_s;
    logic [ENT_W-1:0]  head_next_s;
    logic [ENT_W-1:0]  push_ent_s;
    logic [ENT_W-1:0]  next_ent_s;

    assign accept_s     = wr_req & wr_ready;
    assign stall        = wr_req & ~wr_ready;
    assign push_ent_s   = {wr_addr, wr_char};
    assign last_write_s = (state_q == ST_WRITE) && (hold_cnt_q == HOLD_LAST);
    assign busy         = ~empty_s | (state_q != ST_IDLE);
    // Something remains after this pop: a second stored entry, or the one being pushed right now
    assign more_s       = (level > {{PTR_W{1'b0}}, 1'b1}) | accept_s;

`ifdef VMEM_CLEAR_EN
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(VMEM_CHARS - 1);

    logic              clr_pend_q;
    logic              sweep_q;
    logic [7:0]        clr_char_q;
    logic [ADDR_W-1:0] sweep_cnt_q;

    assign clear_busy = clr_pend_q | sweep_q;
    assign wr_ready   = ~full_s & ~clear_busy;
    assign pop_s      = last_write_s & ~sweep_q;
`else
    assign wr_ready   = ~full_s;
    assign pop_s      = last_write_s;
`endif

    // Pick the entry that follows the head: stored second entry, else bypass the simultaneous push
    always_comb begin
        next_ent_s = head_next_s;
        if (level > {{PTR_W{1'b0}}, 1'b1}) begin
            next_ent_s = head_next_s;
        end else begin
            next_ent_s = push_ent_s;
        end
    end

    vmemq_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (FIFO_DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept_s),
        .pop_i       (pop_s),
        .wdata_i     (push_ent_s),
        .head_o      (head_s),
        .head_next_o (head_next_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .level_o     (level)
    );

    // Write sequencer: state, hold counter and registered text-memory outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            vga_addr    <= '0;
            vga_char    <= 8'd0;
            vga_wen     <= 1'b0;
`ifdef VMEM_CLEAR_EN
            clr_pend_q  <= 1'b0;
            sweep_q     <= 1'b0;
            clr_char_q  <= 8'd0;
            sweep_cnt_q <= '0;
`endif
        end else begin
`ifdef VMEM_CLEAR_EN
            if (clear_req && !clear_busy) begin
                clr_pend_q <= 1'b1;
                clr_char_q <= clear_char;
            end
`endif
            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        vga_addr <= head_s[ENT_W-1:8];
                        vga_char <= head_s[7:0];
                        state_q  <= ST_SETUP;
                    end else begin
`ifdef VMEM_CLEAR_EN
                        if (clr_pend_q) begin
                            state_q <= ST_CLR_WAIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end
                ST_SETUP: begin
                    vga_wen    <= 1'b1;
                    hold_cnt_q <= '0;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end else begin
                        vga_wen <= 1'b0;
`ifdef VMEM_CLEAR_EN
                        if (sweep_q) begin
                            if (sweep_cnt_q == SWEEP_LAST) begin
                                sweep_q <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                sweep_cnt_q <= sweep_cnt_q + ADDR_W'(1);
                                vga_addr    <= sweep_cnt_q + ADDR_W'(1);
                                state_q     <= ST_SETUP;
                            end
                        end else
`endif
                        if (more_s) begin
                            vga_addr <= next_ent_s[ENT_W-1:8];
                            vga_char <= next_ent_s[7:0];
                            state_q  <= ST_SETUP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
`ifdef VMEM_CLEAR_EN
                ST_CLR_WAIT: begin
                    clr_pend_q  <= 1'b0;
                    sweep_q     <= 1'b1;
                    sweep_cnt_q <= '0;
                    vga_addr    <= '0;
                    vga_char    <= clr_char_q;
                    state_q     <= ST_SETUP;
                end
`endif
                default: begin
                    vga_wen <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_write_queue.sv
// tb_vmem_write_queue: directed + randomized stimulus against a queue-of-expected-writes reference model.
`timescale 1ns/1ps
module tb_vmem_write_queue;

    localparam int DEPTH = 8;
    localparam int HOLD  = 2;
    localparam int CHARS = 10240;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  c;
        bit          sw;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [14:0] wr_addr;
    logic [7:0]  wr_char;
    logic        wr_ready, stall, busy, vga_wen;
    logic [3:0]  level;
    logic [14:0] vga_addr;
    logic [7:0]  vga_char;

    logic        h_req;
    logic [14:0] h_addr;
    logic [7:0]  h_char;
    logic        h_ready, h_stall, h_busy, h_wen;
    logic [3:0]  h_level;
    logic [14:0] h_vaddr;
    logic [7:0]  h_vchar;

`ifdef VMEM_CLEAR_EN
    logic        clear_req;
    logic [7:0]  clear_char;
    logic        clear_busy;
    logic        h_cbusy;
`endif

    vmem_write_queue dut (
        .clk (clk), .rst (rst), .wr_req (wr_req), .wr_addr (wr_addr), .wr_char (wr_char),
        .wr_ready (wr_ready), .stall (stall), .busy (busy), .level (level),
        .vga_addr (vga_addr), .vga_char (vga_char), .vga_wen (vga_wen)
`ifdef VMEM_CLEAR_EN
        , .clear_req (clear_req), .clear_char (clear_char), .clear_busy (clear_busy)
`endif
    );

    vmem_write_queue #(.HOLD_CYCLES(1)) u_h1 (
        .clk (clk), .rst (rst), .wr_req (h_req), .wr_addr (h_addr), .wr_char (h_char),
        .wr_ready (h_ready), .stall (h_stall), .busy (h_busy), .level (h_level),
        .vga_addr (h_vaddr), .vga_char (h_vchar), .vga_wen (h_wen)
`ifdef VMEM_CLEAR_EN
        , .clear_req (1'b0), .clear_char (8'h00), .clear_busy (h_cbusy)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_q[$];
    int          model_level = 0;
    bit          model_clr = 1'b0;
    bit          prev_wen = 1'b0;
    int          run = 0;
    logic [22:0] burst_ent;
    int          writes_done = 0;
    int          max_level = 0;
    bit          stall_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: predict ready/stall, advance, then check writes, level and busy against the model
    task automatic step(output bit acc);
        bit          exp_rdy;
        logic [14:0] a;
        logic [7:0]  c;
`ifdef VMEM_CLEAR_EN
        bit          cacc;
        logic [7:0]  cc;
`endif
        #1;
        exp_rdy = (model_level < DEPTH) && !model_clr;
        chk("wr_ready", wr_ready, exp_rdy);
        chk("stall", stall, wr_req && !exp_rdy);
        if (stall === 1'b1) stall_seen = 1'b1;
        acc = wr_req && exp_rdy;
        a = wr_addr;
        c = wr_char;
`ifdef VMEM_CLEAR_EN
        cacc = clear_req && !model_clr;
        cc   = clear_char;
`endif
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back('{a, c, 1'b0});
            model_level++;
        end
`ifdef VMEM_CLEAR_EN
        if (cacc) begin
            model_clr = 1'b1;
            for (int i = 0; i < CHARS; i++) exp_q.push_back('{15'(i), cc, 1'b1});
        end
`endif
        if (vga_wen === 1'b1) begin
            if (!prev_wen) begin
                chk("burst_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("write_addr", vga_addr, exp_q[0].a);
                    chk("write_char", vga_char, exp_q[0].c);
                end
                burst_ent = {vga_addr, vga_char};
                run = 1;
            end else begin
                run++;
                chk("addr_char_stable", {vga_addr, vga_char}, burst_ent);
            end
        end else if (prev_wen) begin
            chk("hold_len", run, HOLD);
            if (exp_q.size() > 0) begin
                if (!exp_q[0].sw) model_level--;
                void'(exp_q.pop_front());
            end
            writes_done++;
            if (model_clr && exp_q.size() == 0) model_clr = 1'b0;
        end
        prev_wen = (vga_wen === 1'b1);
        chk("level", level, model_level);
        if (!model_clr) chk("busy", busy, model_level != 0);
`ifdef VMEM_CLEAR_EN
        chk("clear_busy", clear_busy, model_clr);
`endif
        if (int'(level) > max_level) max_level = int'(level);
    endtask

    task automatic drain(input int budget);
        bit a;
        for (int k = 0; k < budget && (exp_q.size() > 0 || model_level > 0); k++) step(a);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_busy", busy, 1'b0);
    endtask

    initial begin
        bit          a;
        bit          hold_req;
        int          i;
        int          wbase;
        logic [3:0]  h_wen_exp [6];
        logic [14:0] h_addr_exp [6];

        wr_req = 1'b0; wr_addr = '0; wr_char = '0;
        h_req = 1'b0; h_addr = '0; h_char = '0;
`ifdef VMEM_CLEAR_EN
        clear_req = 1'b0; clear_char = 8'h00;
`endif
        rst = 1'b1;
        #1;
        chk("rst_wen", vga_wen, 1'b0);
        chk("rst_addr", vga_addr, 15'h0000);
        chk("rst_char", vga_char, 8'h00);
        chk("rst_level", level, 4'd0);
        chk("rst_busy", busy, 1'b0);
        #12 rst = 1'b0;

        // single store latency
        wr_req = 1'b1; wr_addr = 15'h0123; wr_char = 8'h41;
        step(a);
        wr_req = 1'b0;
        chk("lat_c1_wen", vga_wen, 1'b0);
        step(a);
        chk("lat_c2_addr", vga_addr, 15'h0123);
        chk("lat_c2_char", vga_char, 8'h41);
        chk("lat_c2_wen", vga_wen, 1'b0);
        step(a);
        chk("lat_c3_wen", vga_wen, 1'b1);
        step(a);
        chk("lat_c4_wen", vga_wen, 1'b1);
        step(a);
        chk("lat_c5_wen", vga_wen, 1'b0);
        chk("lat_c5_busy", busy, 1'b0);

        // 16 back-to-back stores held while stalled
        max_level = 0; stall_seen = 1'b0; wbase = writes_done; i = 0;
        for (int k = 0; k < 400 && i < 16; k++) begin
            wr_req = 1'b1; wr_addr = 15'(i); wr_char = 8'(8'h30 + i);
            step(a);
            if (a) i++;
        end
        wr_req = 1'b0;
        chk("b2b_all_accepted", i, 16);
        drain(300);
        chk("b2b_writes", writes_done - wbase, 16);
        chk("b2b_max_level", max_level, DEPTH);
        chk("b2b_stall_seen", stall_seen, 1'b1);

        // randomized traffic, request held while stalled
        hold_req = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!hold_req) begin
                wr_req  = ($urandom_range(0, 99) < 60);
                wr_addr = 15'($urandom);
                wr_char = 8'($urandom);
            end
            step(a);
            hold_req = wr_req && !a;
        end
        wr_req = 1'b0;
        drain(300);

        // reset in the middle of a WRITE with more entries queued
        for (int k = 0; k < 6; k++) begin
            wr_req = 1'b1; wr_addr = 15'(16'h0200 + k); wr_char = 8'(8'h60 + k);
            step(a);
        end
        wr_req = 1'b0;
        for (int k = 0; k < 10 && vga_wen !== 1'b1; k++) step(a);
        chk("pre_rst_wen", vga_wen, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", vga_wen, 1'b0);
        chk("mid_rst_level", level, 4'd0);
        chk("mid_rst_busy", busy, 1'b0);
        exp_q.delete(); model_level = 0; prev_wen = 1'b0; model_clr = 1'b0;
        step(a);
        step(a);
        rst = 1'b0;
        wbase = writes_done;
        for (int k = 0; k < 20; k++) step(a);
        chk("post_rst_no_writes", writes_done - wbase, 0);
        wr_req = 1'b1; wr_addr = 15'h7abc; wr_char = 8'h5a;
        step(a);
        wr_req = 1'b0;
        drain(50);
        chk("post_rst_new_write", writes_done - wbase, 1);

        // HOLD_CYCLES=1 instance: two stores, expect 1-cycle wen and immediate next SETUP
        h_wen_exp  = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        h_addr_exp = '{15'h0, 15'h0005, 15'h0005, 15'h0006, 15'h0006, 15'h0006};
        h_req = 1'b1; h_addr = 15'h0005; h_char = 8'h55;
        for (int k = 0; k < 6; k++) begin
            step(a);
            if (k == 0) begin
                h_addr = 15'h0006; h_char = 8'h66;
            end else begin
                h_req = 1'b0;
            end
            chk("h1_wen", h_wen, h_wen_exp[k][0]);
            if (k > 0) chk("h1_addr", h_vaddr, h_addr_exp[k]);
            if (k == 4) chk("h1_char", h_vchar, 8'h66);
        end
        chk("h1_busy_end", h_busy, 1'b0);

`ifdef VMEM_CLEAR_EN
        // two stores then a clear sweep; second clear_req during the sweep is ignored
        wr_req = 1'b1; wr_addr = 15'h0100; wr_char = 8'h11;
        step(a);
        wr_addr = 15'h0101; wr_char = 8'h22;
        step(a);
        wr_req = 1'b0;
        clear_req = 1'b1; clear_char = 8'h20;
        step(a);
        clear_req = 1'b0; clear_char = 8'hee;
        for (int k = 0; k < 50; k++) step(a);
        clear_req = 1'b1;
        step(a);
        clear_req = 1'b0;
        wbase = writes_done;
        drain(40000);
        chk("clr_done", clear_busy, 1'b0);
        chk("clr_total", writes_done - wbase + 1 > 10000, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
